// File: rtl/fetch_stage.sv
// Purpose: instruction fetch stage; owns the PC and the IF/ID pipeline register.
// Latency: an instruction word presented at imem_addr_o appears in IF/ID one cycle later.
// Backpressure: stall_i freezes PC and IF/ID; imem_valid_i low holds PC and inserts bubbles.
//
// Ports:
//   clk_i, rst_i           clock and asynchronous active-high reset
//   stall_i                hazard-unit hold request (load-use)
//   branch_taken_i         resolved taken branch from a later stage
//   branch_target_i        redirect address (low two bits ignored)
//   imem_addr_o            instruction memory address (the PC)
//   imem_data_i            instruction word at imem_addr_o
//   imem_valid_i           imem_data_i is valid this cycle
//   ifid_instr_o           IF/ID instruction register
//   ifid_pc4_o             IF/ID PC+4 register
//   ifid_valid_o           IF/ID holds a real instruction
//   instr_op_o             opcode field of ifid_instr_o
//   fetch_count_o          saturating count of instructions delivered into IF/ID
module fetch_stage (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_data_i,
    input  logic        imem_valid_i,
    output logic [31:0] ifid_instr_o,
    output logic [31:0] ifid_pc4_o,
    output logic        ifid_valid_o,
    output logic [5:0]  instr_op_o,
    output logic [15:0] fetch_count_o
);

    logic [31:0] pc;
    logic [31:0] pc_plus4;

    // Wraps modulo 2^32 by construction.
    assign pc_plus4    = pc + 32'd4;
    assign imem_addr_o = pc;
    assign instr_op_o  = ifid_instr_o[31:26];

    // Priority: redirect > stall > memory wait > normal fetch.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc            <= 32'h0;
            ifid_instr_o  <= 32'h0;
            ifid_pc4_o    <= 32'h0;
            ifid_valid_o  <= 1'b0;
            fetch_count_o <= 16'h0;
        end else if (branch_taken_i) begin
            // Redirect wins even over a stall; any in-flight imem data is dropped.
            pc            <= {branch_target_i[31:2], 2'b00};
            ifid_instr_o  <= 32'h0;
            ifid_pc4_o    <= 32'h0;
            ifid_valid_o  <= 1'b0;
        end else if (stall_i) begin
            pc            <= pc;
        end else if (!imem_valid_i) begin
            ifid_instr_o  <= 32'h0;
            ifid_pc4_o    <= 32'h0;
            ifid_valid_o  <= 1'b0;
        end else begin
            pc            <= pc_plus4;
            ifid_instr_o  <= imem_data_i;
            ifid_pc4_o    <= pc_plus4;
            ifid_valid_o  <= 1'b1;
            if (fetch_count_o != 16'hFFFF) begin
                fetch_count_o <= fetch_count_o + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Purpose: directed self-checking bench for fetch_stage.
// Latency: inputs are driven 1 time unit after each rising edge, outputs sampled there too.
// Backpressure: exercises stall, memory-wait, redirect, wrap, saturation and async reset.
module tb_fetch_stage;

    logic        clk_i;
    logic        rst_i;
    logic        stall_i;
    logic        branch_taken_i;
    logic [31:0] branch_target_i;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_data_i;
    logic        imem_valid_i;
    logic [31:0] ifid_instr_o;
    logic [31:0] ifid_pc4_o;
    logic        ifid_valid_o;
    logic [5:0]  instr_op_o;
    logic [15:0] fetch_count_o;

    int n_checks = 0;
    int n_fails  = 0;

    fetch_stage dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .stall_i         (stall_i),
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .imem_addr_o     (imem_addr_o),
        .imem_data_i     (imem_data_i),
        .imem_valid_i    (imem_valid_i),
        .ifid_instr_o    (ifid_instr_o),
        .ifid_pc4_o      (ifid_pc4_o),
        .ifid_valid_o    (ifid_valid_o),
        .instr_op_o      (instr_op_o),
        .fetch_count_o   (fetch_count_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Checks the full visible state in one call.
    task automatic chk_all(input string tag, input logic [31:0] addr, input logic [31:0] instr,
                           input logic [31:0] pc4, input logic vld, input logic [15:0] cnt);
        chk({tag, ".addr"},  imem_addr_o, addr);
        chk({tag, ".instr"}, ifid_instr_o, instr);
        chk({tag, ".pc4"},   ifid_pc4_o, pc4);
        chk({tag, ".valid"}, 32'(ifid_valid_o), 32'(vld));
        chk({tag, ".op"},    32'(instr_op_o), 32'(instr[31:26]));
        chk({tag, ".count"}, 32'(fetch_count_o), 32'(cnt));
    endtask

    initial begin
        rst_i           = 1'b1;
        stall_i         = 1'b0;
        branch_taken_i  = 1'b0;
        branch_target_i = 32'h0;
        imem_data_i     = 32'h20080005;
        imem_valid_i    = 1'b1;

        // Reset state, before any clock edge.
        #3;
        chk_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, 16'h0);
        rst_i = 1'b0;

        // First edge after reset fetches from PC 0.
        step();
        chk_all("fetch0", 32'h4, 32'h20080005, 32'h4, 1'b1, 16'd1);
        chk("fetch0.opval", 32'(instr_op_o), 32'h08);
        imem_data_i = 32'h8D090004;
        step();
        chk_all("fetch1", 32'h8, 32'h8D090004, 32'h8, 1'b1, 16'd2);
        chk("fetch1.opval", 32'(instr_op_o), 32'h23);

        // Three-cycle stall at PC 8.
        stall_i     = 1'b1;
        imem_data_i = 32'h11111111;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_all("stall", 32'h8, 32'h8D090004, 32'h8, 1'b1, 16'd2);
        end
        stall_i     = 1'b0;
        imem_data_i = 32'h01234567;
        step();
        chk_all("resume", 32'hC, 32'h01234567, 32'hC, 1'b1, 16'd3);

        // Redirect wins over stall; target low bits are cleared.
        stall_i         = 1'b1;
        branch_taken_i  = 1'b1;
        branch_target_i = 32'h00000043;
        step();
        chk_all("redir_stall", 32'h40, 32'h0, 32'h0, 1'b0, 16'd3);
        stall_i        = 1'b0;
        branch_taken_i = 1'b0;

        // Memory wait for two cycles.
        imem_valid_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            chk_all("memwait", 32'h40, 32'h0, 32'h0, 1'b0, 16'd3);
        end

        // Redirect while memory not valid, to the top of the address space.
        branch_taken_i  = 1'b1;
        branch_target_i = 32'hFFFFFFFE;
        step();
        chk_all("redir_nv", 32'hFFFFFFFC, 32'h0, 32'h0, 1'b0, 16'd3);
        branch_taken_i = 1'b0;

        // PC+4 wraps to zero.
        imem_valid_i = 1'b1;
        imem_data_i  = 32'hAC000000;
        step();
        chk_all("wrap", 32'h0, 32'hAC000000, 32'h0, 1'b1, 16'd4);

        // Asynchronous reset between edges during a stall.
        stall_i = 1'b1;
        #2;
        rst_i = 1'b1;
        #1;
        chk_all("rst_mid", 32'h0, 32'h0, 32'h0, 1'b0, 16'h0);
        rst_i   = 1'b0;
        stall_i = 1'b0;

        // Count up to saturation.
        imem_data_i = 32'h00000020;
        for (int i = 0; i < 65535; i++) begin
            step();
        end
        chk("sat.count", 32'(fetch_count_o), 32'h0000FFFF);
        chk("sat.addr", imem_addr_o, 32'(65535 * 4));
        step();
        chk("sat_hold.count", 32'(fetch_count_o), 32'h0000FFFF);
        chk("sat_hold.valid", 32'(ifid_valid_o), 32'h1);
        chk("sat_hold.addr", imem_addr_o, 32'(65536 * 4));

        // Reset clears the saturated counter.
        #2;
        rst_i = 1'b1;
        #1;
        chk_all("rst_sat", 32'h0, 32'h0, 32'h0, 1'b0, 16'h0);
        rst_i = 1'b0;
        step();
        chk_all("post_rst", 32'h4, 32'h00000020, 32'h4, 1'b1, 16'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
